rgb_fifo_pixel_reader: RTL and testbench

- Sits directly downstream of the 800x480 RGB timing generator, in the rgb_clk domain.
- Pops RGB565 camera pixels from a show-ahead (FWFT) FIFO in step with the display enable.
- Locks to camera frame boundaries using an SOF tag bit carried in each FIFO word, and recovers from underflow or misalignment.
- Delivers delay-matched sync/DE and RGB888 data to the HDMI/LCD output stage.

---
 rtl/rgb_fifo_pixel_reader.sv | 159 +++++++++++++++
 tb/tb_rgb_fifo_pixel_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fifo_pixel_reader.sv
// Pops RGB565 pixels from a FWFT FIFO in step with display enable, locks to SOF-tagged frames, outputs RGB888.
// Optional colour-bar generator with test_en input: define RGB_FIFO_PIXEL_READER_TESTPAT_EN.
module rgb_fifo_pixel_reader #(
  parameter int                DATA_W   = 16,
  parameter int                H_ACTIVE = 800,
  parameter int                V_ACTIVE = 480,
  parameter bit                VS_POL   = 1'b0,
  parameter logic [DATA_W-1:0] FILL_PIX = 16'h0000
) (
  input  logic              rgb_clk,
  input  logic              rgb_rst_n,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [DATA_W:0]   fifo_rd_data,
  input  logic              fifo_empty,
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
  input  logic              test_en,
`endif
  output logic              fifo_rd_en,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_de,
  output logic [23:0]       out_rgb,
  output logic              frame_locked,
  output logic [15:0]       underflow_cnt
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {ST_SEEK, ST_ARMED, ST_RUN} state_t;

  state_t              state, state_nx;
  logic [COL_W-1:0]    col;
  logic [LINE_W-1:0]   line;
  logic                vs_d;
  logic                vs_seen;
  logic                tag;
  logic [DATA_W-1:0]   head_pix;
  logic [DATA_W-1:0]   pix_sel;
  logic                vs_edge;
  logic                first_pix;
  logic                uf_inc;

  function automatic logic [23:0] expand(input logic [DATA_W-1:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;

  function automatic logic [23:0] bar_rgb(input logic [COL_W-1:0] c);
    logic [2:0] idx;
    if (c >= COL_W'(7 * BAR_W)) idx = 3'd7;
    else                         idx = 3'(c / COL_W'(BAR_W));
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  // vs_seen keeps a reset in mid-frame from joining that frame: first_pix
  // only becomes possible once a real vsync edge has cleared the counters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    tag        = fifo_rd_data[DATA_W];
    head_pix   = fifo_rd_data[DATA_W-1:0];
    vs_edge    = (in_vs == VS_POL) && (vs_d != VS_POL);
    first_pix  = in_de && (col == '0) && (line == '0) && vs_seen;
    state_nx   = state;
    fifo_rd_en = 1'b0;
    pix_sel    = FILL_PIX;
    uf_inc     = 1'b0;
    unique case (state)
      ST_SEEK: begin
        fifo_rd_en = ~fifo_empty & ~tag;
        if (~fifo_empty && tag) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (first_pix && ~fifo_empty && tag) begin
          fifo_rd_en = 1'b1;
          pix_sel    = head_pix;
          state_nx   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_de) begin
          if (fifo_empty) begin
            uf_inc   = 1'b1;
            state_nx = ST_SEEK;
          end else if (tag != first_pix) begin
            state_nx = ST_SEEK;
          end else begin
            fifo_rd_en = 1'b1;
            pix_sel    = head_pix;
          end
        end
      end
      default: state_nx = ST_SEEK;
    endcase
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
    if (test_en) begin
      fifo_rd_en = 1'b0;
      uf_inc     = 1'b0;
      state_nx   = ST_SEEK;
    end
`endif
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      state         <= ST_SEEK;
      frame_locked  <= 1'b0;
      out_hs        <= 1'b0;
      out_vs        <= 1'b0;
      out_de        <= 1'b0;
      out_rgb       <= 24'h0;
      underflow_cnt <= 16'h0;
      col           <= '0;
      line          <= '0;
      vs_d          <= ~VS_POL;
      vs_seen       <= 1'b0;
    end else begin
      state        <= state_nx;
      frame_locked <= (state_nx == ST_RUN);
      out_hs       <= in_hs;
      out_vs       <= in_vs;
      out_de       <= in_de;
      vs_d         <= in_vs;
      if (vs_edge) vs_seen <= 1'b1;

      if (vs_edge) begin
        col  <= '0;
        line <= '0;
      end else begin
        col <= in_de ? col + 1'b1 : '0;
        // out_de doubles as the previous-cycle DE for falling-edge detection
        if (out_de && !in_de && line != '1) line <= line + 1'b1;
      end

      out_rgb <= in_de ? expand(pix_sel) : 24'h0;
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
      if (test_en && in_de) out_rgb <= bar_rgb(col);
`endif

      if (uf_inc && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_rgb_fifo_pixel_reader.sv
// Self-checking bench for rgb_fifo_pixel_reader: small raster, queue-based FWFT FIFO and a frame-level reference model.
// Covers the colour-bar path too when RGB_FIFO_PIXEL_READER_TESTPAT_EN is defined.
module tb_rgb_fifo_pixel_reader;

  localparam int          H      = 16;
  localparam int          V      = 4;
  localparam int          H_TOT  = H + 6;
  localparam int          V_TOT  = V + 2;
  localparam int          NPIX   = H * V;
  localparam bit          VS_POL = 1'b0;
  localparam logic [15:0] FILL   = 16'h0000;

  logic        rgb_clk = 1'b0;
  logic        rgb_rst_n = 1'b0;
  logic        in_hs = 1'b0, in_vs = ~VS_POL, in_de = 1'b0;
  logic [16:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en, out_hs, out_vs, out_de, frame_locked;
  logic [23:0] out_rgb;
  logic [15:0] underflow_cnt;
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
  logic        test_en = 1'b0;
`endif

  rgb_fifo_pixel_reader #(
    .DATA_W(16), .H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(VS_POL), .FILL_PIX(FILL)
  ) dut (
    .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
    .test_en(test_en),
`endif
    .fifo_rd_en(fifo_rd_en),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb),
    .frame_locked(frame_locked), .underflow_cnt(underflow_cnt)
  );

  always #5 rgb_clk = ~rgb_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference expansion from arithmetic: replicate the high bits by scaling.
  function automatic logic [23:0] expand_ref(input logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
  endfunction

  function automatic logic [23:0] bar_ref(input int x);
    logic [23:0] bars [8];
    int          b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    b = x / (H / 8);
    if (b > 7) b = 7;
    return bars[b];
  endfunction

  // FIFO contents, raster position and stimulus controls shared with the main sequence
  logic [16:0] fq[$];
  int          hcnt = 0, vcnt = 0;
  int          cur_x = -1, cur_y = -1;
  logic        fe_arm = 1'b0;
  int          fe_x = 0, fe_y = 0;

  // Reference model: frame-level view of lock/arm, built on raster coordinates
  logic        m_locked = 1'b0, m_armed = 1'b0, m_vs_prev = 1'b0, m_frame_ok = 1'b0;
  int          m_uf = 0;
  logic        exp_hs = 0, exp_vs = 0, exp_de = 0, exp_locked = 0;
  logic [23:0] exp_rgb = '0;
  logic [15:0] exp_uf = '0;

  initial begin : bg
    logic        pop_pending, de_i, vs_act, vs_edge, fp, empty_i, tag_i, pop, te;
    logic [15:0] px;
    logic [16:0] junk;
    int          cx, cy;
    pop_pending = 1'b0;
    forever begin
      @(negedge rgb_clk);
      if (!rgb_rst_n) begin
        exp_hs = 0; exp_vs = 0; exp_de = 0; exp_rgb = '0; exp_locked = 0; exp_uf = '0;
      end
      check("out_hs", out_hs, exp_hs);
      check("out_vs", out_vs, exp_vs);
      check("out_de", out_de, exp_de);
      check("out_rgb", out_rgb, exp_rgb);
      check("frame_locked", frame_locked, exp_locked);
      check("underflow_cnt", underflow_cnt, exp_uf);

      if (pop_pending && fq.size() > 0) junk = fq.pop_front();
      pop_pending = 1'b0;

      cx = hcnt; cy = vcnt; cur_x = cx; cur_y = cy;
      de_i  = (cx < H) && (cy < V);
      in_de = de_i;
      in_hs = (cx >= H + 1) && (cx <= H + 3);
      in_vs = (cy == V + 1) ? VS_POL : ~VS_POL;
      empty_i = (fq.size() == 0);
      if (fe_arm && cx == fe_x && cy == fe_y) begin
        empty_i = 1'b1;
        fe_arm  = 1'b0;
      end
      fifo_empty   = empty_i;
      fifo_rd_data = (fq.size() > 0) ? fq[0] : 17'h0;
      tag_i        = fifo_rd_data[16];
      hcnt = (cx == H_TOT - 1) ? 0 : cx + 1;
      if (cx == H_TOT - 1) vcnt = (cy == V_TOT - 1) ? 0 : cy + 1;

      #1;
      te = 1'b0;
`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
      te = test_en;
`endif
      pop = 1'b0;
      px  = FILL;
      if (!rgb_rst_n) begin
        m_locked = 0; m_armed = 0; m_vs_prev = 0; m_frame_ok = 0; m_uf = 0;
        pop = !empty_i && !tag_i;
      end else begin
        vs_act    = (in_vs == VS_POL);
        vs_edge   = vs_act && !m_vs_prev;
        m_vs_prev = vs_act;
        fp = de_i && cx == 0 && cy == 0 && m_frame_ok;
        if (vs_edge) m_frame_ok = 1'b1;
        if (te) begin
          m_locked = 0;
          m_armed  = 0;
        end else if (m_locked) begin
          if (de_i) begin
            if (empty_i) begin
              if (m_uf < 65535) m_uf++;
              m_locked = 0;
            end else if (tag_i != fp) begin
              m_locked = 0;
            end else begin
              pop = 1'b1;
              px  = fifo_rd_data[15:0];
            end
          end
        end else if (m_armed) begin
          if (fp && !empty_i && tag_i) begin
            pop = 1'b1; px = fifo_rd_data[15:0]; m_locked = 1; m_armed = 0;
          end
        end else begin
          if (!empty_i && !tag_i) pop = 1'b1;
          else if (!empty_i && tag_i) m_armed = 1'b1;
        end
        exp_hs     = in_hs;
        exp_vs     = in_vs;
        exp_de     = de_i;
        exp_rgb    = !de_i ? 24'h0 : (te ? bar_ref(cx) : expand_ref(px));
        exp_locked = m_locked;
        exp_uf     = 16'(m_uf);
      end
      check("fifo_rd_en", fifo_rd_en, pop);
      pop_pending = fifo_rd_en;
    end
  end

  // Waits until the raster cycle (x,y) has just been clocked; bounded.
  task automatic wait_at(input int x, input int y);
    for (int i = 0; i < 2 * H_TOT * V_TOT; i++) begin
      @(posedge rgb_clk);
      #2;
      if (cur_x == x && cur_y == y) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_at(%0d,%0d): position not reached within budget", x, y);
  endtask

  task automatic push_frame(input int len, input logic [15:0] first, input int extra_tag);
    for (int i = 0; i < len; i++) begin
      logic [15:0] p;
      p = (i == 0) ? first : 16'($urandom);
      fq.push_back({(i == 0) || (i == extra_tag), p});
    end
  endtask

  typedef struct {
    logic [15:0] pix;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'hF800, 24'hFF0000};
    tbl[1] = '{16'h07E0, 24'h00FF00};
    tbl[2] = '{16'h001F, 24'h0000FF};
    tbl[3] = '{16'h8410, 24'h848284};
    tbl[4] = '{16'hFFFF, 24'hFFFFFF};
    tbl[5] = '{16'h0000, 24'h000000};

    repeat (3) @(posedge rgb_clk);
    #2;
    check("rst_out_rgb", out_rgb, 24'h0);
    check("rst_out_de", out_de, 1'b0);
    check("rst_frame_locked", frame_locked, 1'b0);
    check("rst_underflow_cnt", underflow_cnt, 16'h0);
    rgb_rst_n = 1'b1;

    // Three untagged words discarded in SEEK, then a tagged frame carrying the table pixels
    wait_at(0, V);
    for (int i = 0; i < 3; i++) fq.push_back({1'b0, 16'($urandom)});
    for (int i = 0; i < NPIX; i++) begin
      logic [15:0] p;
      p = (i < 6) ? tbl[i].pix : 16'($urandom);
      fq.push_back({i == 0, p});
    end
    wait_at(10, V);
    check("seek_discard_depth", fq.size(), NPIX);
    for (int i = 0; i < 6; i++) begin
      wait_at(i, 0);
      check($sformatf("expand_vec%0d", i), out_rgb, tbl[i].rgb);
      check($sformatf("locked_vec%0d", i), frame_locked, 1'b1);
    end
    wait_at(H + 1, V - 1);
    check("frame1_underflow", underflow_cnt, 16'h0);
    check("frame1_locked_end", frame_locked, 1'b1);

    // FIFO runs dry mid-frame
    push_frame(NPIX, 16'($urandom), -1);
    fe_arm = 1'b1; fe_x = 5; fe_y = 2;
    wait_at(5, 2);
    check("underflow_rgb", out_rgb, 24'h0);
    check("underflow_cnt_1", underflow_cnt, 16'h1);
    check("underflow_unlock", frame_locked, 1'b0);
    wait_at(H + 1, V - 1);
    push_frame(NPIX, 16'($urandom), -1);
    wait_at(0, 0);
    check("relock_after_underflow", frame_locked, 1'b1);

    // Stray SOF tag mid-line: misalignment, rearm, relock on next frame
    wait_at(H + 1, V - 1);
    fq.push_back({1'b1, 16'($urandom)});
    fq.push_back({1'b0, 16'($urandom)});
    fq.push_back({1'b0, 16'($urandom)});
    fq.push_back({1'b1, 16'h001F});
    push_frame(NPIX - 4, 16'($urandom), -1);
    wait_at(3, 0);
    check("misalign_rgb", out_rgb, 24'h0);
    check("misalign_unlock", frame_locked, 1'b0);
    check("misalign_no_underflow", underflow_cnt, 16'h1);
    wait_at(6, 0);
    check("misalign_stays_unlocked", frame_locked, 1'b0);
    wait_at(0, 0);
    check("relock_after_misalign", frame_locked, 1'b1);
    check("relock_pixel", out_rgb, 24'h0000FF);

    // Asynchronous reset in the middle of a line
    wait_at(4, 1);
    rgb_rst_n = 1'b0;
    #1;
    check("async_rst_rgb", out_rgb, 24'h0);
    check("async_rst_de", out_de, 1'b0);
    check("async_rst_locked", frame_locked, 1'b0);
    check("async_rst_underflow", underflow_cnt, 16'h0);
    fq.delete();
    push_frame(NPIX, 16'h07E0, -1);
    repeat (2) @(posedge rgb_clk);
    #2;
    rgb_rst_n = 1'b1;
    wait_at(H - 1, 1);
    check("no_join_after_reset", frame_locked, 1'b0);
    wait_at(0, 0);
    check("lock_after_vs", frame_locked, 1'b1);
    check("lock_after_vs_rgb", out_rgb, 24'h00FF00);

    // Randomised frames: some short, forcing underflow and relock
    for (int f = 0; f < 4; f++) begin
      wait_at(H + 1, V - 1);
      push_frame(NPIX - (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0),
                 16'($urandom), -1);
    end
    wait_at(H + 1, V - 1);

`ifdef RGB_FIFO_PIXEL_READER_TESTPAT_EN
    test_en = 1'b1;
    wait_at(0, 0);
    check("testpat_col0", out_rgb, 24'hFFFFFF);
    wait_at(H / 8, 0);
    check("testpat_bar1", out_rgb, 24'hFFFF00);
    wait_at(H - 1, 0);
    check("testpat_last", out_rgb, 24'h000000);
    test_en = 1'b0;
    wait_at(H + 1, V - 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
